ctr_request_sequencer: RTL
==========================

// Module: ctr_request_sequencer
// PURPOSE
//  Counter-priority initiator for the control-pulse generator: collects +/- increment requests
//  from NCELL involuntary counter cells, arbitrates by fixed priority, and at each memory-cycle
//  boundary (T12) presents one counter address with INKL and one type line (PINC/MINC/PCDU/MCDU/DINC/SHIFT).
//  Retires the granted request when the generator returns the RSTKX_/RSTKY_ cell-reset acknowledge.
// PARAMETERS
//  NCELL       20        number of counter cells (index 0 = highest priority)
//  BASE_ADDR   6'o24     erasable address of cell 0; CADR = BASE_ADDR + index
//  CDU_MASK    20'h0F800 cells serviced as PCDU/MCDU instead of PINC/MINC
//  SHIFT_MASK  20'h00000 cells serviced as SHIFT (up requests only; down ignored)
//  DINC_MASK   20'h00600 cells serviced as DINC (up or down maps to DINC)
// PORTS
//  CLOCK     in   1      single system clock, all state on rising edge
//  rst_      in   1      asynchronous, active-low reset
//  T12       in   1      one-CLOCK pulse marking end of memory cycle
//  INHCTR    in   1      1 = counter service inhibited (request capture continues)
//  CUP       in   NCELL  per-cell up-count request, one-CLOCK pulse
//  CDN       in   NCELL  per-cell down-count request, one-CLOCK pulse
//  RSTKX_    in   1      cell-reset acknowledge X, active low
//  RSTKY_    in   1      cell-reset acknowledge Y, active low
//  INKL      out  1      counter cycle in progress
//  CADR      out  6      address of granted cell
//  PINC,MINC,PCDU,MCDU,DINC,SHIFT  out 1 each  one-hot type of granted request
//  CTROR     out  1      OR of all pending flags
//  CTRTMO    out  1      one-CLOCK pulse: grant ended at T12 without acknowledge
// BEHAVIOUR
//  Reset: pending flags, INKL, CADR, type lines, CTRTMO = 0; state IDLE. Reset mid-grant abandons
//   the grant with no acknowledge and no CTRTMO.
//  Capture (every CLOCK): UPn<=1 on CUPn, DNn<=1 on CDNn. CUPn and CDNn in the same cycle -> no change.
//   UPn set while DNn pending (or the reverse) -> both cleared (net zero). SHIFT cells ignore CDN.
//  States: IDLE, GRANT.
//   IDLE: on T12 with INHCTR=0 and any flag set -> lowest index n with UPn|DNn; UP wins if both set.
//    Next CLOCK: CADR=BASE_ADDR+n, INKL=1, type line per masks and sign; state GRANT; ack_seen=0.
//   GRANT: outputs held stable. First CLOCK with RSTKX_==0 || RSTKY_==0 -> clear the granted flag,
//    ack_seen=1; further acks in the same grant are ignored.
//    Same-sign request for the granted cell in the ack cycle -> set wins (flag stays 1).
//    Opposite-sign request for the granted cell during GRANT -> normal pairing rule; if it clears
//    the flag before ack, the ack still ends the grant with no further effect.
//    On T12: ack_seen=0 -> CTRTMO pulse, flag retained. Then re-arbitrate on that same T12:
//    a winner exists and INHCTR=0 -> back-to-back GRANT (new CADR/type next CLOCK); else IDLE with
//    INKL, type lines and CADR cleared to 0.
//  Latency: capture to INKL = 1 CLOCK after the next T12 (min 1, max one memory cycle + 1).
//  Ack while IDLE is ignored. T12 and ack in the same cycle: ack applies first, then arbitration.
//  CTROR is combinational from the pending flags. Exactly one type line is high when INKL=1, none when 0.
//  Address add is 6-bit modulo; the configured masks must not overlap (checked by assertion).
// STRUCTURE
//  Package ctr_seq_pkg: state enum {IDLE,GRANT}, type-code enum, and default BASE_ADDR and mask constants.
//  Sub-module ctr_priority_enc: NCELL-wide fixed-priority encoder (index + valid); the rest stays in this module.
// TESTING
//  1 CUP[3] pulse, T12 -> next CLOCK INKL=1, CADR=6'o27, PINC=1; RSTKX_ low -> flag clear;
//    next T12 -> INKL=0, CTROR=0.
//  2 CUP[12] and CDN[12] in the same cycle -> CTROR stays 0.
//    CUP[12], then later CDN[12] -> flags cancel, no grant.
//  3 CUP[15] and CUP[2] pending, T12 -> cell 2 first (CADR 6'o26).
//    Ack then T12 -> back-to-back grant CADR=6'o43 with PCDU=1.
//  4 Grant of cell 5 with no ack by T12 -> CTRTMO pulse, cell 5 re-granted, CTROR stays 1.
//  5 CDN[9] grant (DINC=1); new CDN[9] in the ack cycle -> flag retained, re-granted at next T12.
//  6 rst_ low mid-GRANT -> all outputs 0 asynchronously.
//    INHCTR=1 with pending requests -> no grant across 3 T12 pulses.

Source files
------------

// File: rtl/ctr_seq_pkg.sv
// Shared types and default configuration for the counter request sequencer.
// Type classification helpers map a granted cell to its single active type line.
package ctr_seq_pkg;

    localparam int unsigned NCELL_DFLT = 20;
    localparam int unsigned ADDR_W     = 6;

    localparam logic [ADDR_W-1:0]     BASE_ADDR_DFLT  = 6'o24;
    localparam logic [NCELL_DFLT-1:0] CDU_MASK_DFLT   = 20'h0F800;
    localparam logic [NCELL_DFLT-1:0] SHIFT_MASK_DFLT = 20'h00000;
    localparam logic [NCELL_DFLT-1:0] DINC_MASK_DFLT  = 20'h00600;

    typedef enum logic {IDLE, GRANT} state_e;

    typedef enum logic [2:0] {T_PINC, T_MINC, T_PCDU, T_MCDU, T_DINC, T_SHIFT} ctr_type_e;

    typedef struct packed {
        logic pinc;
        logic minc;
        logic pcdu;
        logic mcdu;
        logic dinc;
        logic shift;
    } type_lines_t;

    // CDU takes precedence, then SHIFT, then DINC; plain cells use the request sign.
    function automatic ctr_type_e classify(input logic is_cdu, input logic is_shift,
                                           input logic is_dinc, input logic up);
        if (is_cdu)   return up ? T_PCDU : T_MCDU;
        if (is_shift) return T_SHIFT;
        if (is_dinc)  return T_DINC;
        return up ? T_PINC : T_MINC;
    endfunction

    function automatic type_lines_t decode_type(input ctr_type_e t);
        type_lines_t l;
        l = '0;
        case (t)
            T_PINC:  l.pinc  = 1'b1;
            T_MINC:  l.minc  = 1'b1;
            T_PCDU:  l.pcdu  = 1'b1;
            T_MCDU:  l.mcdu  = 1'b1;
            T_DINC:  l.dinc  = 1'b1;
            T_SHIFT: l.shift = 1'b1;
            default: l = '0;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/ctr_request_sequencer_if.sv
// Request/grant bundle between counter cells, the control-pulse generator and the sequencer.
interface ctr_request_sequencer_if
    import ctr_seq_pkg::*;
#(
    parameter int unsigned NCELL = NCELL_DFLT
);
    logic              T12;
    logic              INHCTR;
    logic [NCELL-1:0]  CUP;
    logic [NCELL-1:0]  CDN;
    logic              RSTKX_;
    logic              RSTKY_;
    logic              INKL;
    logic [ADDR_W-1:0] CADR;
    logic              PINC;
    logic              MINC;
    logic              PCDU;
    logic              MCDU;
    logic              DINC;
    logic              SHIFT;
    logic              CTROR;
    logic              CTRTMO;

    modport master (
        output T12, INHCTR, CUP, CDN, RSTKX_, RSTKY_,
        input  INKL, CADR, PINC, MINC, PCDU, MCDU, DINC, SHIFT, CTROR, CTRTMO
    );

    modport slave (
        input  T12, INHCTR, CUP, CDN, RSTKX_, RSTKY_,
        output INKL, CADR, PINC, MINC, PCDU, MCDU, DINC, SHIFT, CTROR, CTRTMO
    );
endinterface

// File: rtl/ctr_priority_enc.sv
// Fixed-priority encoder: lowest set index wins.
module ctr_priority_enc #(
    parameter int unsigned N  = 20,
    parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    output logic [IW-1:0] idx_c,
    output logic          valid_c
);
    always_comb begin
        idx_c   = '0;
        valid_c = 1'b0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx_c   = IW'(i);
                valid_c = 1'b1;
            end
        end
    end
endmodule

// File: rtl/ctr_request_sequencer.sv
// Collects per-cell counter requests and grants one cell per memory cycle at T12,
// retiring it on the RSTKX_/RSTKY_ acknowledge.
module ctr_request_sequencer
    import ctr_seq_pkg::*;
#(
    parameter int unsigned       NCELL      = NCELL_DFLT,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = BASE_ADDR_DFLT,
    parameter logic [NCELL-1:0]  CDU_MASK   = NCELL'(CDU_MASK_DFLT),
    parameter logic [NCELL-1:0]  SHIFT_MASK = NCELL'(SHIFT_MASK_DFLT),
    parameter logic [NCELL-1:0]  DINC_MASK  = NCELL'(DINC_MASK_DFLT)
) (
    input  logic                    CLOCK,
    input  logic                    rst_,
    ctr_request_sequencer_if.slave  bus
);
    localparam int unsigned IW = (NCELL > 1) ? $clog2(NCELL) : 1;
    localparam logic [NCELL-1:0] MASK_OVERLAP =
        (CDU_MASK & SHIFT_MASK) | (CDU_MASK & DINC_MASK) | (SHIFT_MASK & DINC_MASK);

    state_e            state_q, state_d;
    logic [NCELL-1:0]  up_q, dn_q, up_a, dn_a, up_d, dn_d;
    logic [NCELL-1:0]  cdn_eff, cup_set, cdn_set;
    logic [IW-1:0]     gnt_idx_q, gnt_idx_d, win_idx;
    logic              gnt_up_q, gnt_up_d, win_valid;
    logic              ack_seen_q, ack_seen_d, ack_now;
    logic              inkl_q, inkl_d, tmo_q, tmo_d;
    logic [ADDR_W-1:0] cadr_q, cadr_d;
    type_lines_t       lines_q, lines_d;

    // SHIFT cells never count down; simultaneous up/down on one cell is a no-op.
    assign cdn_eff = bus.CDN & ~SHIFT_MASK;
    assign cup_set = bus.CUP & ~cdn_eff;
    assign cdn_set = cdn_eff & ~bus.CUP;
    assign ack_now = (state_q == GRANT) && !ack_seen_q && (!bus.RSTKX_ || !bus.RSTKY_);

    // Acknowledge retires the granted flag first, then this cycle's requests are paired in.
    always_comb begin : flag_update
        up_a = up_q;
        dn_a = dn_q;
        if (ack_now) begin
            if (gnt_up_q) up_a[gnt_idx_q] = 1'b0;
            else          dn_a[gnt_idx_q] = 1'b0;
        end
        up_d = up_a;
        dn_d = dn_a;
        for (int n = 0; n < int'(NCELL); n++) begin
            if (cup_set[n]) begin
                if (dn_a[n]) begin
                    up_d[n] = 1'b0;
                    dn_d[n] = 1'b0;
                end else begin
                    up_d[n] = 1'b1;
                end
            end else if (cdn_set[n]) begin
                if (up_a[n]) begin
                    up_d[n] = 1'b0;
                    dn_d[n] = 1'b0;
                end else begin
                    dn_d[n] = 1'b1;
                end
            end
        end
    end

    ctr_priority_enc #(.N(NCELL), .IW(IW)) u_enc (
        .req     (up_a | dn_a),
        .idx_c   (win_idx),
        .valid_c (win_valid)
    );

    always_comb begin : fsm_next
        state_d    = state_q;
        gnt_idx_d  = gnt_idx_q;
        gnt_up_d   = gnt_up_q;
        ack_seen_d = ack_seen_q;
        inkl_d     = inkl_q;
        cadr_d     = cadr_q;
        lines_d    = lines_q;
        tmo_d      = 1'b0;

        if (ack_now) ack_seen_d = 1'b1;

        if (bus.T12) begin
            if (state_q == GRANT && !ack_seen_q && !ack_now) tmo_d = 1'b1;
            if (win_valid && !bus.INHCTR) begin
                state_d    = GRANT;
                gnt_idx_d  = win_idx;
                gnt_up_d   = up_a[win_idx];
                ack_seen_d = 1'b0;
                inkl_d     = 1'b1;
                cadr_d     = BASE_ADDR + ADDR_W'(win_idx);
                lines_d    = decode_type(classify(CDU_MASK[win_idx], SHIFT_MASK[win_idx],
                                                  DINC_MASK[win_idx], up_a[win_idx]));
            end else if (state_q == GRANT) begin
                state_d    = IDLE;
                ack_seen_d = 1'b0;
                inkl_d     = 1'b0;
                cadr_d     = '0;
                lines_d    = '0;
            end
        end
    end

    always_ff @(posedge CLOCK or negedge rst_) begin
        if (!rst_) begin
            state_q    <= IDLE;
            up_q       <= '0;
            dn_q       <= '0;
            gnt_idx_q  <= '0;
            gnt_up_q   <= 1'b0;
            ack_seen_q <= 1'b0;
            inkl_q     <= 1'b0;
            cadr_q     <= '0;
            lines_q    <= '0;
            tmo_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            up_q       <= up_d;
            dn_q       <= dn_d;
            gnt_idx_q  <= gnt_idx_d;
            gnt_up_q   <= gnt_up_d;
            ack_seen_q <= ack_seen_d;
            inkl_q     <= inkl_d;
            cadr_q     <= cadr_d;
            lines_q    <= lines_d;
            tmo_q      <= tmo_d;
        end
    end

    assign bus.INKL   = inkl_q;
    assign bus.CADR   = cadr_q;
    assign bus.PINC   = lines_q.pinc;
    assign bus.MINC   = lines_q.minc;
    assign bus.PCDU   = lines_q.pcdu;
    assign bus.MCDU   = lines_q.mcdu;
    assign bus.DINC   = lines_q.dinc;
    assign bus.SHIFT  = lines_q.shift;
    assign bus.CTRTMO = tmo_q;
    assign bus.CTROR  = |(up_q | dn_q);

    a_masks_disjoint: assert property (@(posedge CLOCK) disable iff (!rst_) MASK_OVERLAP == '0)
        else $error("ctr_request_sequencer: type masks overlap");

endmodule
